pcie_tx_scrambler_128b: RTL and testbench
=========================================

# pcie_tx_scrambler_128b

Transmit-side 128b/130b scrambler for one lane, Gen3 and above. It sits between the TX framing/ordered-set mux and the 128b/130b encoder. It is the transmit counterpart of the receive descrambler, and its output must descramble to the original payload through that block. It applies the Gen3 LFSR, x^23+x^21+x^16+x^8+x^5+x^2+1, per block type, and handles the LFSR hold rule for SKP, the LFSR reseed rule for EIEOS, and the bypass rule for ordered-set symbol 0.

## Interface
Parameters:
- DW, 128: block payload width; fixed at 128, which is 16 symbols.
- LFSR_WIDTH, 23: LFSR state width.
- LANE_SEED, 23'h1DBFBC: LFSR seed for this lane, loaded at reset and on EIEOS.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_data  in  128  unscrambled block. Symbol k is in_data[8k+7:8k]; bit 0 of each symbol is transmitted first.
- in_sync_hdr  in  2  sync header: 2'b10 is a data block, 2'b01 is an ordered-set block.
- in_valid  in  1  input block valid.
- in_ready  out  1  block accepts input this cycle.
- out_data  out  128  scrambled block.
- out_sync_hdr  out  2  sync header, passed through unchanged.
- out_valid  out  1  output block valid.
- out_ready  in  1  downstream accepts output.
- scrambler_enable  in  1  0 = bypass. The LFSR still advances, so lock is preserved.
- hdr_err  out  1  one-cycle pulse when an accepted block has sync header 00 or 11.

## Operation
- **Accept condition:** a block is accepted when in_valid && in_ready.
- **Keystream:** for each data bit, in transmit order (symbol 0 bit 0 first through symbol 15 bit 7), ks = lfsr[22]. After each bit: lfsr <= {lfsr[21:0],1'b0} ^ (lfsr[22] ? 23'h210125 : 0). Scrambled bit = d ^ ks. Compute all 128 steps combinationally in one cycle.
- **Block classification** of the accepted block, in priority order:
  - **Header 00/11:** data passes unmodified, LFSR holds, hdr_err pulses on the cycle after acceptance.
  - **Data (10):** all 16 symbols are scrambled; LFSR advances 128 steps.
  - **SKP OS (01, symbol 0 = 8'hAA):** no symbol scrambled; LFSR holds.
  - **EIEOS (01, symbol 0 = 8'h00):** no symbol scrambled; LFSR loads LANE_SEED after the block.
  - **Other OS (01; TS1 1E, TS2 2D, EIOS 66, SDS E1, …):** symbol 0 is unscrambled but its 8 LFSR steps still occur; symbols 1–15 are scrambled; LFSR advances 128 steps.
- **Bypass:** when scrambler_enable = 0, XOR masking is suppressed and the LFSR update rules above remain in force.
  - scrambler_enable is sampled on the accept cycle.
- **LFSR update:** occurs only on accept, never on stall.

## Timing
- **Output register:** single output stage; latency is 1 cycle from accept to out_valid.
- **in_ready:** in_ready = !out_valid || out_ready, which gives full throughput of one block per cycle.
- **Stall (out_valid && !out_ready):** out_data, out_sync_hdr, and out_valid hold stable; in_ready = 0; LFSR frozen.
- **Simultaneous events:** when an EIEOS is accepted and the next block is accepted on the following cycle, that next block uses the seed.
- **Reset (asynchronous, any time, including mid-stall):**
  - lfsr = LANE_SEED, out_valid = 0, out_data = 0, out_sync_hdr = 2'b00, hdr_err = 0.
  - in_ready = 1 after release.
  - A block in flight is dropped.
- **Idle:** in_valid = 0 leaves the LFSR and output unchanged; out_valid falls after a pending output is taken.

## Test plan
- **Reset, then data:** after reset, one data block with in_data = 0 and header 10 → out_data equals the first 128 keystream bits from seed 1DBFBC, matching the bit-serial reference model. Feeding out_data through the RX descrambler returns 0.
- **SKP transparency:** the sequence data A, SKP (AA×16, header 01), data B → SKP emerges unchanged as AA×16. B's output is identical to the run "data A, data B" with no SKP in between.
- **EIEOS reseed:** 5 random data blocks, then EIEOS (00/FF pattern), then a zero data block → EIEOS output is unchanged. The zero block's output equals the first post-reset keystream from the first scenario.
- **TS1 symbol 0 bypass:** a TS1 block (symbol 0 = 1E, header 01) immediately after reset → out symbol 0 = 1E. Symbols 1–15 equal the input XOR keystream bits 8–127. The following block uses keystream bits 128+.
- **Backpressure:** random in_valid and out_ready patterns over 1000 blocks → no block is lost or duplicated, out_data is stable while stalled, and the output matches the model.
- **Header error and bypass:** a header 11 block → output is unchanged, hdr_err pulses for 1 cycle, and the LFSR holds. With scrambler_enable = 0 and a data block → output equals input, and the next enabled block matches the model advanced by 128 steps.

Source files
------------

// File: rtl/pcie_tx_scrambler_128b.sv
// Transmit-side 128b/130b scrambler for one lane (Gen3+ LFSR x^23+x^21+x^16+x^8+x^5+x^2+1).
// Scrambles a full 16-symbol block per cycle with SKP hold, EIEOS reseed and OS symbol-0 bypass.
module pcie_tx_scrambler_128b #(
    parameter int DW = 128,
    parameter int LFSR_WIDTH = 23,
    parameter logic [LFSR_WIDTH-1:0] LANE_SEED = 23'h1DBFBC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW-1:0]         in_data,
    input  logic [1:0]            in_sync_hdr,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DW-1:0]         out_data,
    output logic [1:0]            out_sync_hdr,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  scrambler_enable,
    output logic                  hdr_err
);

    localparam logic [LFSR_WIDTH-1:0] POLY = 23'h210125;
    localparam int NSYM = DW / 8;

    logic [LFSR_WIDTH-1:0] lfsr_reg;
    logic [LFSR_WIDTH-1:0] lfsr_next;
    logic [LFSR_WIDTH-1:0] lfsr_adv;
    logic [DW-1:0]         ks;
    logic [DW-1:0]         scr_mask;
    logic [NSYM-1:0]       sym_scr;

    logic [DW-1:0]         out_data_reg;
    logic [1:0]            out_sync_hdr_reg;
    logic                  out_valid_reg;
    logic                  hdr_err_reg;

    logic accept;
    logic hdr_bad;
    logic is_data;
    logic is_os;
    logic is_skp;
    logic is_eieos;
    logic is_os_other;

    assign in_ready    = !out_valid_reg || out_ready;
    assign accept      = in_valid && in_ready;

    assign hdr_bad     = (in_sync_hdr[1] == in_sync_hdr[0]);
    assign is_data     = (in_sync_hdr == 2'b10);
    assign is_os       = (in_sync_hdr == 2'b01);
    assign is_skp      = is_os && (in_data[7:0] == 8'hAA);
    assign is_eieos    = is_os && (in_data[7:0] == 8'h00);
    assign is_os_other = is_os && !is_skp && !is_eieos;

    // Unrolled bit-serial LFSR: keystream bit i is the MSB before step i.
    always_comb begin
        logic [LFSR_WIDTH-1:0] state;
        state = lfsr_reg;
        ks    = '0;
        for (int i = 0; i < DW; i++) begin
            ks[i] = state[LFSR_WIDTH-1];
            state = {state[LFSR_WIDTH-2:0], 1'b0} ^ (state[LFSR_WIDTH-1] ? POLY : '0);
        end
        lfsr_adv = state;
    end

    // Symbol 0 of a non-SKP/non-EIEOS ordered set is sent in the clear.
    generate
        for (genvar gi = 0; gi < NSYM; gi++) begin : g_sym
            if (gi == 0) begin : g_sym0
                assign sym_scr[gi] = scrambler_enable && is_data;
            end else begin : g_symn
                assign sym_scr[gi] = scrambler_enable && (is_data || is_os_other);
            end
            assign scr_mask[gi*8 +: 8] = {8{sym_scr[gi]}} & ks[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        lfsr_next = lfsr_reg;
        if (accept) begin
            if (is_data || is_os_other) begin
                lfsr_next = lfsr_adv;
            end else if (is_eieos) begin
                lfsr_next = LANE_SEED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg         <= LANE_SEED;
            out_valid_reg    <= 1'b0;
            out_data_reg     <= '0;
            out_sync_hdr_reg <= 2'b00;
            hdr_err_reg      <= 1'b0;
        end else begin
            lfsr_reg    <= lfsr_next;
            hdr_err_reg <= accept && hdr_bad;
            if (in_ready) begin
                out_valid_reg <= in_valid;
            end
            if (accept) begin
                out_data_reg     <= in_data ^ scr_mask;
                out_sync_hdr_reg <= in_sync_hdr;
            end
        end
    end

    assign out_data     = out_data_reg;
    assign out_sync_hdr = out_sync_hdr_reg;
    assign out_valid    = out_valid_reg;
    assign hdr_err      = hdr_err_reg;

endmodule

// File: tb/tb_pcie_tx_scrambler_128b.sv
// Scoreboard bench for pcie_tx_scrambler_128b: stimulus pushes expected blocks from a
// bit-serial reference model, a negedge monitor pops and compares every output block.
module tb_pcie_tx_scrambler_128b;

    localparam logic [22:0] SEED = 23'h1DBFBC;
    localparam logic [22:0] POLY = 23'h210125;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [127:0] in_data = '0;
    logic [1:0]   in_sync_hdr = 2'b10;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] out_data;
    logic [1:0]   out_sync_hdr;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic         scrambler_enable = 1'b1;
    logic         hdr_err;

    pcie_tx_scrambler_128b dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_sync_hdr(in_sync_hdr), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_sync_hdr(out_sync_hdr), .out_valid(out_valid), .out_ready(out_ready),
        .scrambler_enable(scrambler_enable), .hdr_err(hdr_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] data;
        logic [1:0]   hdr;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] out_log[$];
    int           checks = 0;
    int           errors = 0;
    int           pushed = 0;
    int           popped = 0;
    logic [22:0]  model_lfsr = SEED;
    bit           bp_mode = 0;

    function automatic void keystream(input logic [22:0] seed, output logic [127:0] ks,
                                      output logic [22:0] fin);
        logic [22:0] s;
        s = seed;
        for (int i = 0; i < 128; i++) begin
            ks[i] = s[22];
            s = {s[21:0], 1'b0} ^ (s[22] ? POLY : 23'h0);
        end
        fin = s;
    endfunction

    function automatic logic [127:0] model_block(input logic [127:0] d, input logic [1:0] h,
                                                 input logic en);
        logic [127:0] ks;
        logic [22:0]  fin;
        logic [127:0] e;
        keystream(model_lfsr, ks, fin);
        e = d;
        if (h == 2'b10) begin
            if (en) e = d ^ ks;
            model_lfsr = fin;
        end else if (h == 2'b01) begin
            if (d[7:0] == 8'h00) begin
                model_lfsr = SEED;
            end else if (d[7:0] != 8'hAA) begin
                ks[7:0] = 8'h00;
                if (en) e = d ^ ks;
                model_lfsr = fin;
            end
        end
        return e;
    endfunction

    task automatic check128(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic send(input logic [127:0] d, input logic [1:0] h, input logic en);
        int n;
        exp_t e;
        in_data = d;
        in_sync_hdr = h;
        scrambler_enable = en;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            e.data = model_block(d, h, en);
            e.hdr  = h;
            exp_q.push_back(e);
            pushed++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: %0d blocks outstanding, expected 0", exp_q.size());
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        model_lfsr = SEED;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 128'h0 || out_sync_hdr !== 2'b00 ||
            hdr_err !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%h hdr=%b err=%b rdy=%b expected 0/0/00/0/1",
                     out_valid, out_data, out_sync_hdr, hdr_err, in_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: output compare, stall stability and hdr_err pulse timing.
    logic         stall_prev = 1'b0;
    logic         err_pending = 1'b0;
    logic [127:0] held_data;
    logic [1:0]   held_hdr;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev  = 1'b0;
                err_pending = 1'b0;
            end else begin
                checks++;
                if (hdr_err !== err_pending) begin
                    errors++;
                    $display("FAIL hdr_err: got %b expected %b", hdr_err, err_pending);
                end
                if (stall_prev) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== held_data || out_sync_hdr !== held_hdr) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b data=%h hdr=%b expected 1 %h %b",
                                 out_valid, out_data, out_sync_hdr, held_data, held_hdr);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got %h expected no block", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        popped++;
                        if (out_data !== e.data || out_sync_hdr !== e.hdr) begin
                            errors++;
                            $display("FAIL out_block: got %h/%b expected %h/%b",
                                     out_data, out_sync_hdr, e.data, e.hdr);
                        end
                    end
                    out_log.push_back(out_data);
                end
                stall_prev  = out_valid && !out_ready;
                held_data   = out_data;
                held_hdr    = out_sync_hdr;
                err_pending = in_valid && in_ready && (in_sync_hdr == 2'b00 || in_sync_hdr == 2'b11);
            end
        end
    end

    // Random downstream backpressure, updated just after the stimulus moves.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [127:0] z0, b1, b2, a, b, ts1, ks, skp, eie, r;
        logic [22:0]  fin;
        int           idx, sel;

        #1;
        do_reset();

        // Reset then all-zero data block: output is the raw keystream from the seed.
        idx = out_log.size();
        send('0, 2'b10, 1'b1);
        drain();
        z0 = out_log[idx];
        keystream(SEED, ks, fin);
        check128("descramble_zero", z0 ^ ks, 128'h0);

        // SKP transparency: B after SKP matches B without SKP.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        skp = {16{8'hAA}};
        do_reset();
        idx = out_log.size();
        send(a, 2'b10, 1'b1);
        send(skp, 2'b01, 1'b1);
        send(b, 2'b10, 1'b1);
        drain();
        check128("skp_passthru", out_log[idx+1], skp);
        b1 = out_log[idx+2];
        do_reset();
        idx = out_log.size();
        send(a, 2'b10, 1'b1);
        send(b, 2'b10, 1'b1);
        drain();
        b2 = out_log[idx+1];
        check128("skp_hold_lfsr", b1, b2);

        // EIEOS reseed.
        eie = {{15{8'hFF}}, 8'h00};
        idx = out_log.size();
        for (int i = 0; i < 5; i++) begin
            r = {$urandom, $urandom, $urandom, $urandom};
            send(r, 2'b10, 1'b1);
        end
        send(eie, 2'b01, 1'b1);
        send('0, 2'b10, 1'b1);
        drain();
        check128("eieos_passthru", out_log[idx+5], eie);
        check128("eieos_reseed", out_log[idx+6], z0);

        // TS1 right after reset: symbol 0 clear, rest scrambled by keystream bits 8..127.
        do_reset();
        ts1 = {$urandom, $urandom, $urandom, $urandom};
        ts1[7:0] = 8'h1E;
        idx = out_log.size();
        send(ts1, 2'b01, 1'b1);
        send('0, 2'b10, 1'b1);
        drain();
        check128("ts1_sym0", {120'h0, out_log[idx][7:0]}, {120'h0, 8'h1E});
        check128("ts1_syms", {out_log[idx][127:8], 8'h00}, {ts1[127:8] ^ ks[127:8], 8'h00});

        // Bad header, then bypassed data, then enabled data.
        idx = out_log.size();
        a = {$urandom, $urandom, $urandom, $urandom};
        send(a, 2'b11, 1'b1);
        send(b, 2'b10, 1'b0);
        send('0, 2'b10, 1'b1);
        send(a, 2'b00, 1'b1);
        drain();
        check128("hdr11_passthru", out_log[idx], a);
        check128("bypass_passthru", out_log[idx+1], b);

        // Reset while stalled drops the held block.
        out_ready = 1'b0;
        send(a, 2'b10, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b1;
        send('0, 2'b10, 1'b1);
        drain();

        // Random backpressure over 1000 mixed blocks.
        pushed = 0;
        popped = 0;
        bp_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            r = {$urandom, $urandom, $urandom, $urandom};
            sel = $urandom_range(0, 11);
            case (sel)
                6:  send(skp, 2'b01, 1'b1);
                7:  send(eie, 2'b01, 1'b1);
                8:  begin r[7:0] = 8'h1E; send(r, 2'b01, 1'b1); end
                9:  begin r[7:0] = 8'h2D; send(r, 2'b01, 1'b1); end
                10: send(r, 2'($urandom_range(0, 1) * 3), 1'b1);
                11: send(r, 2'b10, 1'b0);
                default: send(r, 2'b10, 1'b1);
            endcase
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        out_ready = 1'b1;
        drain();
        checks++;
        if (popped != pushed) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs expected %0d", popped, pushed);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
